gate_tt_checker: RTL

//  Stimulus/checker for a 2-input gate primitive under test (e.g. nor2_prim).
//  - Drives a/b through the four input vectors and samples y after a settle window.
//  - Compares each sample against an expected truth table.
//  - Reports pass/fail, a mismatch count and the failing vectors.
//  - Sits beside the gate as its self-test driver; one gate per instance.

---
 rtl/gate_tt_pkg.sv | 23 ++
 rtl/gate_tt_settle_timer.sv | 41 ++++
 rtl/gate_tt_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and truth-table constants for the 2-input gate self-test checker.
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Expected y per vector, bit index = {a,b}
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [3:0] vec_flag(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Loadable down-counter that times the hold window before each sample.
module gate_tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(SETTLE_CYCLES + 1);
  // Loading SETTLE_CYCLES-1 makes the window exactly SETTLE_CYCLES cycles long
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, decrement toward zero, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gate_tt_checker.sv
// Self-test driver/checker for one 2-input gate: sweeps {a,b}, samples y, scores vs EXP_TT.
// Optional GATE_TT_CHECKER_OBS_TT_EN adds obs_tt, the y values seen in the final sweep.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [3:0] EXP_TT        = TT_NOR,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         NUM_SWEEPS    = 1,
  parameter int         CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
`ifdef GATE_TT_CHECKER_OBS_TT_EN
  output logic [3:0]       obs_tt,
`endif
  output logic [3:0]       fail_vec
);

  localparam int                 SWEEP_W    = (NUM_SWEEPS > 1) ? $clog2(NUM_SWEEPS) : 1;
  localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(NUM_SWEEPS - 1);
  localparam logic [CNT_W-1:0]   ERR_MAX    = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [3:0]         fail_q, fail_d;

  logic               start_acc_s;
  logic               mismatch_s;
  logic               more_s;
  logic               expired_s;
  logic               timer_load_s;
  logic [CNT_W-1:0]   err_sat_s;
  logic [3:0]         fail_set_s;

  gate_tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load_s),
    .en     (state_q == SETTLE),
    .expired(expired_s)
  );

  // Score of the vector currently being sampled
  always_comb begin
    start_acc_s = start & ~abort & ((state_q == IDLE) | (state_q == DONE));
    mismatch_s  = (y_i != EXP_TT[idx_q]);
    more_s      = (idx_q != 2'd3) | (sweep_q != LAST_SWEEP);
    if (mismatch_s) begin
      err_sat_s  = (err_q == ERR_MAX) ? err_q : (err_q + CNT_W'(1'b1));
      fail_set_s = fail_q | vec_flag(idx_q);
    end else begin
      err_sat_s  = err_q;
      fail_set_s = fail_q;
    end
  end

  // Next-state and next-output logic; abort outranks start
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sweep_d      = sweep_q;
    ab_d         = ab_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_d       = fail_q;
    timer_load_s = 1'b0;
    if (abort) begin
      state_d = IDLE;
      ab_d    = 2'b00;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else if (start_acc_s) begin
      state_d      = SETTLE;
      idx_d        = 2'd0;
      sweep_d      = {SWEEP_W{1'b0}};
      ab_d         = 2'b00;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      err_d        = {CNT_W{1'b0}};
      fail_d       = 4'b0000;
      timer_load_s = 1'b1;
    end else begin
      case (state_q)
        SETTLE: begin
          if (expired_s) begin
            state_d = SAMPLE;
          end else begin
            state_d = SETTLE;
          end
        end
        SAMPLE: begin
          err_d  = err_sat_s;
          fail_d = fail_set_s;
          if (more_s) begin
            idx_d        = idx_q + 2'd1;
            ab_d         = idx_q + 2'd1;
            state_d      = SETTLE;
            timer_load_s = 1'b1;
            if (idx_q == 2'd3) begin
              sweep_d = sweep_q + SWEEP_W'(1'b1);
            end else begin
              sweep_d = sweep_q;
            end
          end else begin
            state_d = DONE;
            ab_d    = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_sat_s == {CNT_W{1'b0}});
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
          ab_d    = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      sweep_q <= {SWEEP_W{1'b0}};
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= {CNT_W{1'b0}};
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sweep_q <= sweep_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a_o       = ab_q[1];
  assign b_o       = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

`ifdef GATE_TT_CHECKER_OBS_TT_EN
  logic [3:0] obs_q, obs_d;

  // Observed truth table, overwritten only during the last sweep
  always_comb begin
    obs_d = obs_q;
    if (start_acc_s) begin
      obs_d = 4'b0000;
    end else if (!abort && (state_q == SAMPLE) && (sweep_q == LAST_SWEEP)) begin
      obs_d[idx_q] = y_i;
    end else begin
      obs_d = obs_q;
    end
  end

  // Observed truth-table register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_q <= 4'b0000;
    end else begin
      obs_q <= obs_d;
    end
  end

  assign obs_tt = obs_q;
`endif

endmodule
